// File: rtl/ttt_pkg.sv
// ============================================================================
// ttt_pkg : shared constants, FSM state encoding and cursor helpers
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package ttt_pkg;

    localparam int NUM_CELLS = 9;
    localparam int CELL_W    = 4;

    localparam logic [CELL_W-1:0] LAST_CELL = CELL_W'(NUM_CELLS - 1);
    localparam logic [CELL_W-1:0] MAX_MOVES = CELL_W'(NUM_CELLS);

    localparam logic P1 = 1'b0;
    localparam logic P2 = 1'b1;

    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_TURN   = 5'b00010,
        ST_COMMIT = 5'b00100,
        ST_RESULT = 5'b01000,
        ST_OVER   = 5'b10000
    } state_t;

    function automatic logic [CELL_W-1:0] cell_dec(input logic [CELL_W-1:0] c);
        return (c == '0) ? LAST_CELL : c - CELL_W'(1);
    endfunction

    function automatic logic [CELL_W-1:0] cell_inc(input logic [CELL_W-1:0] c);
        return (c == LAST_CELL) ? '0 : c + CELL_W'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ttt_btn_edge.sv
// ============================================================================
// ttt_btn_edge : per-bit rising-edge detector with one registered history bit
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module ttt_btn_edge #(
    parameter int WIDTH = 6
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] i_btn,
    output logic [WIDTH-1:0] o_rise
);

    logic [WIDTH-1:0] r_hist;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_hist <= '0;
        end else begin
            r_hist <= i_btn;
        end
    end

    assign o_rise = i_btn & ~r_hist;

endmodule

`default_nettype wire

// File: rtl/ttt_turn_ctrl.sv
// ============================================================================
// ttt_turn_ctrl : turn sequencer / button arbiter in front of the game core
// Optional per-turn forfeit timer enabled by defining TURN_TIMER_EN.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module ttt_turn_ctrl
    import ttt_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000000
)
(
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic                 p1_left,
    input  logic                 p1_right,
    input  logic                 p1_enter,
    input  logic                 p2_left,
    input  logic                 p2_right,
    input  logic                 p2_enter,
    input  logic [NUM_CELLS-1:0] occ_mask,
    input  logic                 game_over,
    output logic                 move_valid,
    input  logic                 move_ready,
    output logic [CELL_W-1:0]    move_cell,
    output logic                 move_player,
    output logic [CELL_W-1:0]    cursor,
    output logic                 player,
    output logic                 illegal,
    output logic                 turn_timeout,
    output logic [CELL_W-1:0]    move_count
);

    logic [5:0] w_rise;

    ttt_btn_edge #(
        .WIDTH (6)
    ) u_btn_edge (
        .Clk    (Clk),
        .Reset  (Reset),
        .i_btn  ({p2_enter, p2_right, p2_left, p1_enter, p1_right, p1_left}),
        .o_rise (w_rise)
    );

    state_t            r_state, w_state_n;
    logic [CELL_W-1:0] r_cursor, w_cursor_n;
    logic              r_player, w_player_n;
    logic              r_move_valid, w_move_valid_n;
    logic [CELL_W-1:0] r_move_cell, w_move_cell_n;
    logic              r_move_player, w_move_player_n;
    logic              r_illegal, w_illegal_n;
    logic [CELL_W-1:0] r_move_count, w_move_count_n;

    // Only the side to move is listened to.
    logic w_left, w_right, w_enter, w_legal_enter;
    assign w_left        = (r_player == P1) ? w_rise[0] : w_rise[3];
    assign w_right       = (r_player == P1) ? w_rise[1] : w_rise[4];
    assign w_enter       = (r_player == P1) ? w_rise[2] : w_rise[5];
    assign w_legal_enter = (r_state == ST_TURN) && w_enter && !occ_mask[r_cursor];

`ifdef TURN_TIMER_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    logic [TIMER_W-1:0] r_timer, w_timer_n;
    logic               r_timeout, w_timeout_n;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state       <= ST_IDLE;
            r_cursor      <= '0;
            r_player      <= P1;
            r_move_valid  <= 1'b0;
            r_move_cell   <= '0;
            r_move_player <= P1;
            r_illegal     <= 1'b0;
            r_move_count  <= '0;
`ifdef TURN_TIMER_EN
            r_timer       <= '0;
            r_timeout     <= 1'b0;
`endif
        end else begin
            r_state       <= w_state_n;
            r_cursor      <= w_cursor_n;
            r_player      <= w_player_n;
            r_move_valid  <= w_move_valid_n;
            r_move_cell   <= w_move_cell_n;
            r_move_player <= w_move_player_n;
            r_illegal     <= w_illegal_n;
            r_move_count  <= w_move_count_n;
`ifdef TURN_TIMER_EN
            r_timer       <= w_timer_n;
            r_timeout     <= w_timeout_n;
`endif
        end
    end

    always_comb begin
        w_state_n       = r_state;
        w_cursor_n      = r_cursor;
        w_player_n      = r_player;
        w_move_valid_n  = r_move_valid;
        w_move_cell_n   = r_move_cell;
        w_move_player_n = r_move_player;
        w_illegal_n     = 1'b0;
        w_move_count_n  = r_move_count;
`ifdef TURN_TIMER_EN
        w_timer_n       = r_timer;
        w_timeout_n     = 1'b0;
`endif

        case (r_state)
            ST_IDLE: begin
                if (Start) begin
                    w_state_n      = ST_TURN;
                    w_cursor_n     = '0;
                    w_player_n     = P1;
                    w_move_count_n = '0;
                end
            end

            ST_TURN: begin
                if (w_enter) begin
                    if (occ_mask[r_cursor]) begin
                        w_illegal_n = 1'b1;
                    end else begin
                        w_move_valid_n  = 1'b1;
                        w_move_cell_n   = r_cursor;
                        w_move_player_n = r_player;
                        w_state_n       = ST_COMMIT;
                    end
                end else if (w_left && !w_right) begin
                    w_cursor_n = cell_dec(r_cursor);
                end else if (w_right && !w_left) begin
                    w_cursor_n = cell_inc(r_cursor);
                end
`ifdef TURN_TIMER_EN
                // A legal enter on the expiry cycle beats the forfeit.
                if (!w_legal_enter) begin
                    if (r_timer == TIMER_LAST) begin
                        w_timeout_n = 1'b1;
                        w_player_n  = (r_player == P1) ? P2 : P1;
                        w_timer_n   = '0;
                    end else begin
                        w_timer_n = r_timer + TIMER_W'(1);
                    end
                end
`endif
            end

            ST_COMMIT: begin
                if (move_ready) begin
                    w_move_valid_n = 1'b0;
                    w_move_count_n = (r_move_count == MAX_MOVES) ? r_move_count
                                                                 : r_move_count + CELL_W'(1);
                    w_state_n      = ST_RESULT;
                end
            end

            ST_RESULT: begin
                if (game_over || (r_move_count == MAX_MOVES)) begin
                    w_state_n = ST_OVER;
                end else begin
                    w_player_n = (r_player == P1) ? P2 : P1;
                    w_state_n  = ST_TURN;
                end
            end

            ST_OVER: begin
                if (Start) begin
                    w_state_n = ST_IDLE;
                end
            end

            default: begin
                w_state_n = ST_IDLE;
            end
        endcase

`ifdef TURN_TIMER_EN
        if ((w_state_n == ST_TURN) && (r_state != ST_TURN)) begin
            w_timer_n = '0;
        end
`endif
    end

    assign move_valid  = r_move_valid;
    assign move_cell   = r_move_cell;
    assign move_player = r_move_player;
    assign cursor      = r_cursor;
    assign player      = r_player;
    assign illegal     = r_illegal;
    assign move_count  = r_move_count;

`ifdef TURN_TIMER_EN
    assign turn_timeout = r_timeout;
`else
    assign turn_timeout = 1'b0;
    logic w_unused;
    assign w_unused = w_legal_enter;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ttt_turn_ctrl.sv
// ============================================================================
// tb_ttt_turn_ctrl : directed self-checking bench for ttt_turn_ctrl
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_ttt_turn_ctrl;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic       p1_left = 1'b0, p1_right = 1'b0, p1_enter = 1'b0;
    logic       p2_left = 1'b0, p2_right = 1'b0, p2_enter = 1'b0;
    logic [8:0] occ_mask = '0;
    logic       game_over = 1'b0;
    logic       move_ready = 1'b0;
    logic       move_valid, move_player, player, illegal, turn_timeout;
    logic [3:0] move_cell, cursor, move_count;

    int checks = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    ttt_turn_ctrl #(
        .TIMEOUT_CYCLES (16)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Start        (Start),
        .p1_left      (p1_left),
        .p1_right     (p1_right),
        .p1_enter     (p1_enter),
        .p2_left      (p2_left),
        .p2_right     (p2_right),
        .p2_enter     (p2_enter),
        .occ_mask     (occ_mask),
        .game_over    (game_over),
        .move_valid   (move_valid),
        .move_ready   (move_ready),
        .move_cell    (move_cell),
        .move_player  (move_player),
        .cursor       (cursor),
        .player       (player),
        .illegal      (illegal),
        .turn_timeout (turn_timeout),
        .move_count   (move_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // 0..2 = p1 left/right/enter, 3..5 = p2 left/right/enter
    task automatic set_btn(input int b, input logic v);
        case (b)
            0: p1_left  = v;
            1: p1_right = v;
            2: p1_enter = v;
            3: p2_left  = v;
            4: p2_right = v;
            default: p2_enter = v;
        endcase
    endtask

    task automatic press(input int b);
        set_btn(b, 1'b1);
        @(negedge Clk);
        set_btn(b, 1'b0);
        @(negedge Clk);
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        @(negedge Clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cursor"}, cursor, 0);
        chk({tag, "_player"}, player, 0);
        chk({tag, "_valid"}, move_valid, 0);
        chk({tag, "_cell"}, move_cell, 0);
        chk({tag, "_mplayer"}, move_player, 0);
        chk({tag, "_illegal"}, illegal, 0);
        chk({tag, "_timeout"}, turn_timeout, 0);
        chk({tag, "_count"}, move_count, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge Clk);
        chk_reset_vals("reset");
        Reset = 1'b0;
        @(negedge Clk);
        pulse_start();

`ifdef TURN_TIMER_EN
        // P1 idles: forfeit after 16 TURN cycles
        repeat (14) @(negedge Clk);
        chk("tmo_early", turn_timeout, 0);
        @(negedge Clk);
        chk("tmo_fire", turn_timeout, 1);
        chk("tmo_player", player, 1);
        chk("tmo_novalid", move_valid, 0);
        @(negedge Clk);
        chk("tmo_pulse_end", turn_timeout, 0);
        // P2 enters exactly on the expiry cycle: legal enter wins
        repeat (14) @(negedge Clk);
        p2_enter = 1'b1;
        @(negedge Clk);
        p2_enter = 1'b0;
        chk("exp_enter_valid", move_valid, 1);
        chk("exp_enter_tmo", turn_timeout, 0);
        chk("exp_enter_mplayer", move_player, 1);
        chk("exp_enter_player", player, 1);
        // Reset mid-COMMIT drops the request
        #2 Reset = 1'b1;
        @(negedge Clk);
        chk_reset_vals("midcommit");
        Reset = 1'b0;
`else
        // Test 1: P1 moves cursor, P2 ignored
        repeat (3) press(1);
        chk("t1_cursor3", cursor, 3);
        press(4);
        chk("t1_p2_ignored", cursor, 3);

        // Test 2: wrap both ways, simultaneous left+right
        repeat (3) press(0);
        chk("t2_cursor0", cursor, 0);
        press(0);
        chk("t2_wrap_left", cursor, 8);
        press(1);
        chk("t2_wrap_right", cursor, 0);
        p1_left = 1'b1; p1_right = 1'b1;
        @(negedge Clk);
        p1_left = 1'b0; p1_right = 1'b0;
        @(negedge Clk);
        chk("t2_lr_same", cursor, 0);

        // Test 3: enter on occupied cell
        repeat (4) press(1);
        chk("t3_cursor4", cursor, 4);
        occ_mask = 9'h010;
        p1_enter = 1'b1;
        @(negedge Clk);
        p1_enter = 1'b0;
        chk("t3_illegal", illegal, 1);
        chk("t3_novalid", move_valid, 0);
        chk("t3_player", player, 0);
        @(negedge Clk);
        chk("t3_illegal_end", illegal, 0);

        // Test 4: legal enter, stalled handshake
        repeat (2) press(0);
        press(2);
        chk("t4_valid", move_valid, 1);
        chk("t4_cell", move_cell, 2);
        chk("t4_mplayer", move_player, 0);
        p1_right = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            chk("t4_hold_valid", move_valid, 1);
            chk("t4_hold_cell", move_cell, 2);
        end
        p1_right = 1'b0;
        chk("t4_cursor_frozen", cursor, 2);
        move_ready = 1'b1;
        @(negedge Clk);
        move_ready = 1'b0;
        chk("t4_valid_drop", move_valid, 0);
        chk("t4_count1", move_count, 1);
        chk("t4_player_result", player, 0);
        @(negedge Clk);
        chk("t4_player1", player, 1);

        // Test 5: P2 moves, core reports game over
        occ_mask = 9'h014;
        press(4);
        chk("t5_p2_cursor", cursor, 3);
        press(5);
        chk("t5_cell", move_cell, 3);
        chk("t5_mplayer", move_player, 1);
        game_over = 1'b1;
        move_ready = 1'b1;
        @(negedge Clk);
        move_ready = 1'b0;
        @(negedge Clk);
        game_over = 1'b0;
        press(1);
        press(4);
        press(5);
        chk("t5_over_cursor", cursor, 3);
        chk("t5_over_count", move_count, 2);
        chk("t5_over_player", player, 1);
        chk("t5_over_valid", move_valid, 0);
        pulse_start();
        chk("t5_idle_cursor", cursor, 3);
        pulse_start();
        chk("t5_new_cursor", cursor, 0);
        chk("t5_new_count", move_count, 0);
        chk("t5_new_player", player, 0);

        // Full board: nine accepted moves end the game
        occ_mask = '0;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) press((i % 2 == 0) ? 1 : 4);
            press((i % 2 == 0) ? 2 : 5);
            chk("full_cell", move_cell, i);
            chk("full_mplayer", move_player, i % 2);
            occ_mask[i] = 1'b1;
            move_ready = 1'b1;
            @(negedge Clk);
            move_ready = 1'b0;
            @(negedge Clk);
        end
        chk("full_count9", move_count, 9);
        chk("full_player", player, 0);
        press(1);
        chk("full_over_cursor", cursor, 8);
        press(2);
        chk("full_over_novalid", move_valid, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
